// File: rtl/if_stage_prefetch.sv
// Instruction fetch stage with pipelined imem requests, an in-order PC tag
// queue and a prefetch FIFO toward decode; redirects squash stale responses.
module if_stage_prefetch #(
  parameter logic [31:0] CPU_RESET_VECTOR = 32'h0,
  parameter int          FIFO_DEPTH       = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        PCNextSrc,
  input  logic        PCJumpTargetSrc,
  input  logic [31:0] pc_plus_imm,
  input  logic [31:0] pc_target_alu,
  output logic        o_imem_req_valid,
  input  logic        i_imem_req_ready,
  output logic [31:0] o_imem_req_addr,
  input  logic        i_imem_rsp_valid,
  input  logic [31:0] i_imem_rsp_data,
  output logic        if_valid,
  input  logic        id_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_p4,
  output logic [31:0] if_instr
);

  localparam int CW = $clog2(2*FIFO_DEPTH+1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(2*FIFO_DEPTH);
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] MAX_INF = CW'(2*FIFO_DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   fifo_pc    [FIFO_DEPTH];
  logic [31:0]   fifo_instr [FIFO_DEPTH];
  logic [31:0]   tag_q      [2*FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [TW-1:0] tag_wr, tag_rd;
  logic [CW-1:0] count, inflight, discard;
  logic [CW-1:0] live, inflight_nxt;
  logic [CW:0]   credit_used;
  logic [31:0]   target;
  logic          redirect, fire, drop, push, pop;

  assign redirect = PCNextSrc;
  assign target   = PCJumpTargetSrc ? pc_target_alu : pc_plus_imm;

  // Live requests are the ones whose data will still land in the FIFO.
  assign live        = inflight - discard;
  assign credit_used = {1'b0, live} + {1'b0, count};

  assign o_imem_req_valid = rstn & ~redirect
                          & (credit_used < DEPTH_W)
                          & (inflight < MAX_INF);
  assign o_imem_req_addr  = {fetch_pc[31:2], 2'b00};

  assign fire = o_imem_req_valid & i_imem_req_ready;
  assign drop = i_imem_rsp_valid & (discard != '0);
  assign push = i_imem_rsp_valid & (discard == '0) & ~redirect;
  assign pop  = if_valid & id_ready & ~redirect;

  assign inflight_nxt = inflight + CW'(fire) - CW'(i_imem_rsp_valid);

  assign if_valid = rstn & (count != '0);
  assign if_pc    = fifo_pc[rd_ptr];
  assign if_pc_p4 = if_pc + 32'd4;
  assign if_instr = fifo_instr[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      fetch_pc <= CPU_RESET_VECTOR;
      count    <= '0;
      inflight <= '0;
      discard  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tag_wr   <= '0;
      tag_rd   <= '0;
    end else begin
      inflight <= inflight_nxt;
      if (fire)
        tag_wr <= tag_wr + TW'(1);
      if (i_imem_rsp_valid)
        tag_rd <= tag_rd + TW'(1);
      if (redirect) begin
        fetch_pc <= {target[31:2], 2'b00};
        count    <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        discard  <= inflight_nxt;
      end else begin
        if (fire)
          fetch_pc <= fetch_pc + 32'd4;
        if (drop)
          discard <= discard - CW'(1);
        if (push)
          wr_ptr <= wr_ptr + PW'(1);
        if (pop)
          rd_ptr <= rd_ptr + PW'(1);
        if (push && !pop)
          count <= count + CW'(1);
        else if (pop && !push)
          count <= count - CW'(1);
      end
    end
  end

  // Storage needs no reset: validity lives in the counters and pointers.
  always_ff @(posedge clk) begin
    if (fire)
      tag_q[tag_wr] <= o_imem_req_addr;
    if (push) begin
      fifo_pc[wr_ptr]    <= tag_q[tag_rd];
      fifo_instr[wr_ptr] <= i_imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_if_stage_prefetch.sv
// Scoreboard bench for if_stage_prefetch: memory model, issue model and
// a negedge monitor comparing decode-side output against expected entries.
module tb_if_stage_prefetch;

  logic        clk = 1'b0;
  logic        rstn;
  logic        PCNextSrc, PCJumpTargetSrc;
  logic [31:0] pc_plus_imm, pc_target_alu;
  logic        o_imem_req_valid, i_imem_req_ready;
  logic [31:0] o_imem_req_addr;
  logic        i_imem_rsp_valid;
  logic [31:0] i_imem_rsp_data;
  logic        if_valid, id_ready;
  logic [31:0] if_pc, if_pc_p4, if_instr;

  if_stage_prefetch #(.CPU_RESET_VECTOR(32'h0), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rstn(rstn),
    .PCNextSrc(PCNextSrc), .PCJumpTargetSrc(PCJumpTargetSrc),
    .pc_plus_imm(pc_plus_imm), .pc_target_alu(pc_target_alu),
    .o_imem_req_valid(o_imem_req_valid),
    .i_imem_req_ready(i_imem_req_ready),
    .o_imem_req_addr(o_imem_req_addr),
    .i_imem_rsp_valid(i_imem_rsp_valid),
    .i_imem_rsp_data(i_imem_rsp_data),
    .if_valid(if_valid), .id_ready(id_ready),
    .if_pc(if_pc), .if_pc_p4(if_pc_p4), .if_instr(if_instr)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; bit stale; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

  int errors = 0;
  int checks = 0;
  req_t out_q[$];
  ent_t exp_q[$];
  logic [31:0] model_pc;
  logic [31:0] cur_addr;
  bit cur_stale = 1'b1;
  bit rsp_en;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory: answers each accepted request one cycle later, in order.
  always @(posedge clk) begin
    req_t r;
    #2;
    if (rsp_en && out_q.size() > 0) begin
      r = out_q.pop_front();
      cur_addr = r.addr;
      cur_stale = r.stale;
      i_imem_rsp_valid = 1'b1;
      i_imem_rsp_data = mem_word(r.addr);
    end else begin
      i_imem_rsp_valid = 1'b0;
      i_imem_rsp_data = 32'h0;
    end
  end

  // Issue model and output monitor; evaluates what the next posedge does.
  always @(negedge clk) begin
    ent_t e;
    if (!rstn) begin
      chk("rst_req_valid", {31'b0, o_imem_req_valid}, 32'd0);
      chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
      out_q.delete();
      exp_q.delete();
      model_pc = 32'h0;
      cur_stale = 1'b1;
    end else if (PCNextSrc) begin
      chk("redir_req_valid", {31'b0, o_imem_req_valid}, 32'd0);
      foreach (out_q[i]) out_q[i].stale = 1'b1;
      exp_q.delete();
      model_pc = (PCJumpTargetSrc ? pc_target_alu : pc_plus_imm)
                 & 32'hFFFF_FFFC;
    end else begin
      if (if_valid && id_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got pc %h expected none", if_pc);
        end else begin
          e = exp_q.pop_front();
          chk("out_pc", if_pc, e.pc);
          chk("out_pc_p4", if_pc_p4, e.pc + 32'd4);
          chk("out_instr", if_instr, e.instr);
        end
      end
      if (i_imem_rsp_valid && !cur_stale)
        exp_q.push_back('{cur_addr, mem_word(cur_addr)});
      if (o_imem_req_valid && i_imem_req_ready) begin
        chk("req_addr", o_imem_req_addr, model_pc);
        out_q.push_back('{model_pc, 1'b0});
        model_pc = model_pc + 32'd4;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_if_valid(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: if_valid timeout got 0 expected 1", name);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    rstn = 1'b0;
    PCNextSrc = 1'b0;
    PCJumpTargetSrc = 1'b0;
    pc_plus_imm = 32'h0;
    pc_target_alu = 32'h0;
    i_imem_req_ready = 1'b1;
    id_ready = 1'b1;
    rsp_en = 1'b1;
    i_imem_rsp_valid = 1'b0;
    i_imem_rsp_data = 32'h0;
    step(2);
    rstn = 1'b1;

    // Streaming from the reset vector
    @(negedge clk);
    chk("first_req_valid", {31'b0, o_imem_req_valid}, 32'd1);
    chk("first_req_addr", o_imem_req_addr, 32'h0);
    wait_if_valid("first_out", ok);
    if (ok) begin
      chk("first_if_pc", if_pc, 32'h0);
      chk("first_if_pc_p4", if_pc_p4, 32'h4);
    end
    step(8);

    // Decode stall fills the FIFO and throttles requests
    id_ready = 1'b0;
    step(10);
    @(negedge clk);
    chk("full_if_valid", {31'b0, if_valid}, 32'd1);
    chk("full_req_valid", {31'b0, o_imem_req_valid}, 32'd0);
    step(1);
    id_ready = 1'b1;
    step(10);

    // Redirect to 0x10 with the memory not ready for 3 cycles
    PCNextSrc = 1'b1;
    PCJumpTargetSrc = 1'b0;
    pc_plus_imm = 32'h10;
    i_imem_req_ready = 1'b0;
    step(1);
    PCNextSrc = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_req_valid", {31'b0, o_imem_req_valid}, 32'd1);
      chk("hold_req_addr", o_imem_req_addr, 32'h10);
      if (i < 2) step(1);
    end
    step(1);
    i_imem_req_ready = 1'b1;
    wait_if_valid("hold_out", ok);
    if (ok) chk("hold_if_pc", if_pc, 32'h10);
    step(6);

    // Two requests in flight, then JALR redirect to 0x103
    rsp_en = 1'b0;
    step(4);
    @(negedge clk);
    chk("inflight_req_valid", {31'b0, o_imem_req_valid}, 32'd0);
    step(1);
    PCNextSrc = 1'b1;
    PCJumpTargetSrc = 1'b1;
    pc_target_alu = 32'h103;
    step(1);
    PCNextSrc = 1'b0;
    rsp_en = 1'b1;
    @(negedge clk);
    chk("jalr_req_valid", {31'b0, o_imem_req_valid}, 32'd1);
    chk("jalr_req_addr", o_imem_req_addr, 32'h100);
    wait_if_valid("jalr_out", ok);
    if (ok) chk("jalr_if_pc", if_pc, 32'h100);
    step(6);

    // Buffered entry + response + redirect in the same cycle
    rsp_en = 1'b0;
    step(4);
    id_ready = 1'b0;
    rsp_en = 1'b1;
    step(1);
    PCNextSrc = 1'b1;
    PCJumpTargetSrc = 1'b0;
    pc_plus_imm = 32'h200;
    @(negedge clk);
    chk("squash_pre_if_valid", {31'b0, if_valid}, 32'd1);
    chk("squash_pre_rsp_valid", {31'b0, i_imem_rsp_valid}, 32'd1);
    step(1);
    PCNextSrc = 1'b0;
    id_ready = 1'b1;
    @(negedge clk);
    chk("squash_if_valid", {31'b0, if_valid}, 32'd0);
    chk("squash_req_addr", o_imem_req_addr, 32'h200);
    wait_if_valid("squash_out", ok);
    if (ok) chk("squash_if_pc", if_pc, 32'h200);
    step(6);

    // Address wrap at 2^32 (target low bits cleared)
    PCNextSrc = 1'b1;
    PCJumpTargetSrc = 1'b0;
    pc_plus_imm = 32'hFFFF_FFFF;
    step(1);
    PCNextSrc = 1'b0;
    wait_if_valid("wrap_out", ok);
    if (ok) begin
      chk("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
      chk("wrap_if_pc_p4", if_pc_p4, 32'h0);
    end
    step(6);

    // Back-to-back redirects: the last one wins
    PCNextSrc = 1'b1;
    PCJumpTargetSrc = 1'b0;
    pc_plus_imm = 32'h300;
    step(1);
    PCJumpTargetSrc = 1'b1;
    pc_target_alu = 32'h404;
    step(1);
    PCNextSrc = 1'b0;
    wait_if_valid("b2b_out", ok);
    if (ok) chk("b2b_if_pc", if_pc, 32'h404);
    step(6);

    // Reset mid-operation with buffered entries
    id_ready = 1'b0;
    step(6);
    @(negedge clk);
    chk("prereset_if_valid", {31'b0, if_valid}, 32'd1);
    step(1);
    rstn = 1'b0;
    @(negedge clk);
    chk("midrst_if_valid", {31'b0, if_valid}, 32'd0);
    step(1);
    rstn = 1'b1;
    id_ready = 1'b1;
    @(negedge clk);
    chk("refetch_req_valid", {31'b0, o_imem_req_valid}, 32'd1);
    chk("refetch_req_addr", o_imem_req_addr, 32'h0);
    wait_if_valid("refetch_out", ok);
    if (ok) chk("refetch_if_pc", if_pc, 32'h0);
    step(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
